riscv_processor: RTL and testbench
==================================

RISCV_PROCESSOR -- requirements
Module: riscv_processor

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_DEPTH, default 256: data memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port pc_out, output, 32 bits: current program counter.
REQ-006 SHALL have port instruction_out, output, 32 bits: instruction fetched at pc_out.
REQ-007 SHALL contain these sub-instances, reachable hierarchically:
- instruction_fetch_unit, with array instruction_memory[0:IMEM_DEPTH-1].
- register_file_unit, with array reg_array[0:31].
- memory_unit, with array memory[0:DMEM_DEPTH-1].
REQ-008 SHALL expose these top-level nets: pc, fetched_instruction, opcode, funct3, funct7, rd, rs1, rs2, imm, alu_control (4b), regwrite_control, imm_control, mem_read_control, mem_write_control, alu_result, zero_flag, mem_data_in, mem_address, mem_data_out, read_data1, read_data2, reg_write_data, operand_a, operand_b.

Function
REQ-009 SHALL be single-cycle: fetch, decode, execute, memory access and writeback all complete within one clock period.
REQ-010 SHALL fetch fetched_instruction = instruction_memory[pc[9:2]] combinationally; pc SHALL wrap modulo IMEM_DEPTH*4.
REQ-011 SHALL update pc <= pc+4 on every rising edge when not in reset; there are no branches or jumps.
REQ-012 SHALL decode the instruction as: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
REQ-013 SHALL form imm as follows, else 0:
- I-type (0x13, 0x03): sign-extended [31:20].
- S-type (0x23): sign-extended {[31:25],[11:7]}.
REQ-014 SHALL support these instructions:
- R-type (0x33): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- I-ALU (0x13): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- Loads (0x03): LB, LH, LW, LBU, LHU.
- Stores (0x23): SB, SH, SW.
REQ-015 SHALL use these alu_control codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SLTU=1000, XOR=1001, SLL=1010, SRL=1011, SRA=1100. Shift amount = operand_b[4:0].
REQ-016 SHALL set operand_a = read_data1, and operand_b = imm when imm_control=1, else read_data2. Loads and stores SHALL use ADD.
REQ-017 SHALL set zero_flag = (alu_result==0).
REQ-018 SHALL set regwrite_control=1 for R, I-ALU and load instructions only. reg_write_data SHALL be the load result for loads, else alu_result.
REQ-019 SHALL keep x0 reading 0 and SHALL ignore writes to x0. Register reads SHALL be combinational.
REQ-020 SHALL use mem_address = alu_result as a byte address; the word index is mem_address[9:2]; lanes are little-endian, selected by mem_address[1:0].
REQ-021 SHALL perform loads as follows: mem_data_out is the addressed word; LB/LH sign-extend the addressed byte/half; LBU/LHU zero-extend it; LH/LHU use mem_address[1].
REQ-022 SHALL perform stores on the rising edge: mem_data_in = read_data2; SB/SH write only the addressed lane(s) and leave the other bytes unchanged; SW writes the whole word.
REQ-023 SHALL treat any unsupported opcode (including 0x00000000) as a NOP: no register write and no memory write.
REQ-024 SHALL ignore misaligned low address bits for LW/SW, and mem_address[0] for halfword accesses.

Reset
REQ-025 SHALL set pc to 0 on a rising edge while reset=0.
REQ-026 SHALL suppress register-file and data-memory writes during the reset cycle.
REQ-027 SHALL NOT clear register file or memory contents on reset.
REQ-028 SHALL give pc_out=0 and instruction_out=instruction_memory[0] in the first cycle after reset is released.

Configuration
REQ-029 With RISCV_SUBWORD_EN defined: LB, LH, LBU, LHU, SB and SH SHALL behave per REQ-021/REQ-022.
REQ-030 Without RISCV_SUBWORD_EN: only LW/SW SHALL execute; other load/store funct3 values SHALL be NOPs.

Verification
REQ-031 After reset, with x5=0xAAAAAAAA and x6=4, executing SB x5,4(x6) (0x00530223) SHALL give memory[2][7:0]=0xAA with the other bytes unchanged.
REQ-032 With x7=0xBBBBBBBB and x8=0xC, executing SW x7,0(x8) (0x00742023) SHALL give memory[3]=0xBBBBBBBB.
REQ-033 With x5=0, memory[0]=0x11111111 and memory[3]=0x44444444:
- LW x6,0(x5) SHALL give x6=0x11111111.
- LB x7,12(x5) SHALL give x7=0x00000044.
REQ-034 With x5=1 and x6=2:
- ADDI x7,x5,10 SHALL give x7=0xB.
- ORI x12,x6,4 SHALL give x12=0x6.
REQ-035 With x5=1 and x6=2:
- ADD x7,x6,x5 SHALL give x7=3.
- SUB x7,x5,x6 SHALL give x7=0xFFFFFFFF and zero_flag=0.
REQ-036 Holding reset low mid-program SHALL return pc to 0 and SHALL leave reg_array unchanged.

Source files
------------

// File: rtl/riscv_processor.sv
// Single-cycle RV32I subset: register/immediate ALU ops, loads and stores, no control flow.
// Define RISCV_SUBWORD_EN to add byte/halfword accesses (LB, LH, LBU, LHU, SB, SH).

module instruction_fetch_unit #(
    parameter int IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] fetched_instruction
);
    localparam int          IW      = $clog2(IMEM_DEPTH);
    localparam logic [31:0] PC_SPAN = 32'(IMEM_DEPTH * 4);

    logic [31:0] instruction_memory [0:IMEM_DEPTH-1];
    logic [31:0] pc_next;

    assign pc_next             = pc + 32'd4;
    assign fetched_instruction = instruction_memory[pc[IW+1:2]];

    always_ff @(posedge clk) begin
        if (!reset)                  pc <= '0;
        else if (pc_next >= PC_SPAN) pc <= '0;
        else                         pc <= pc_next;
    end
endmodule

module register_file_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [4:0]  read_addr1,
    input  logic [4:0]  read_addr2,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);
    logic [31:0] reg_array [0:31];

    // x0 is hardwired to zero on the read side; its storage is never written.
    assign read_data1 = (read_addr1 == 5'd0) ? '0 : reg_array[read_addr1];
    assign read_data2 = (read_addr2 == 5'd0) ? '0 : reg_array[read_addr2];

    always_ff @(posedge clk) begin
        if (reset && write_enable && write_addr != 5'd0)
            reg_array[write_addr] <= write_data;
    end
endmodule

module memory_unit #(
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);
    localparam int DW = $clog2(DMEM_DEPTH);

    logic [31:0]   memory [0:DMEM_DEPTH-1];
    logic [DW-1:0] word_index;
    logic          unused_address;

    assign word_index     = address[DW+1:2];
    assign unused_address = ^{address[31:DW+2], address[1:0]};
    assign read_data      = memory[word_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 4; b++)
                if (byte_enable[b]) memory[word_index][8*b +: 8] <= write_data[8*b +: 8];
        end
    end
endmodule

module riscv_processor #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out
);
    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;

    logic [31:0] pc, fetched_instruction;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu_control;
    logic        regwrite_control, imm_control, mem_read_control, mem_write_control;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic [31:0] mem_data_in, mem_address, mem_data_out;
    logic [31:0] read_data1, read_data2, reg_write_data;
    logic [31:0] operand_a, operand_b;
    logic [31:0] load_data, store_data;
    logic [3:0]  byte_enable;
    logic        load_ok, store_ok;
    logic        unused_zero_flag;

    instruction_fetch_unit #(.IMEM_DEPTH(IMEM_DEPTH)) instruction_fetch_unit (
        .clk                 (clk),
        .reset               (reset),
        .pc                  (pc),
        .fetched_instruction (fetched_instruction)
    );

    register_file_unit register_file_unit (
        .clk          (clk),
        .reset        (reset),
        .write_enable (regwrite_control),
        .read_addr1   (rs1),
        .read_addr2   (rs2),
        .write_addr   (rd),
        .write_data   (reg_write_data),
        .read_data1   (read_data1),
        .read_data2   (read_data2)
    );

    memory_unit #(.DMEM_DEPTH(DMEM_DEPTH)) memory_unit (
        .clk         (clk),
        .reset       (reset),
        .byte_enable (byte_enable),
        .address     (mem_address),
        .write_data  (store_data),
        .read_data   (mem_data_out)
    );

    assign pc_out           = pc;
    assign instruction_out  = fetched_instruction;
    assign unused_zero_flag = zero_flag;

    assign opcode = fetched_instruction[6:0];
    assign rd     = fetched_instruction[11:7];
    assign funct3 = fetched_instruction[14:12];
    assign rs1    = fetched_instruction[19:15];
    assign rs2    = fetched_instruction[24:20];
    assign funct7 = fetched_instruction[31:25];

`ifdef RISCV_SUBWORD_EN
    assign load_ok  = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign store_ok = (funct3 inside {3'b000, 3'b001, 3'b010});
`else
    assign load_ok  = (funct3 == 3'b010);
    assign store_ok = (funct3 == 3'b010);
`endif

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        imm               = '0;
        alu_control       = ALU_ADD;
        regwrite_control  = 1'b0;
        imm_control       = 1'b0;
        mem_read_control  = 1'b0;
        mem_write_control = 1'b0;
        case (opcode)
            OP_R: begin
                alu_control      = alu_op(funct3, funct7[5]);
                regwrite_control = (funct7 == 7'h00) ||
                                   (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OP_I: begin
                imm         = {{20{fetched_instruction[31]}}, fetched_instruction[31:20]};
                imm_control = 1'b1;
                alu_control = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
                // Shift-immediates carry funct7 in the upper immediate bits; other encodings are illegal.
                case (funct3)
                    3'b001:  regwrite_control = (funct7 == 7'h00);
                    3'b101:  regwrite_control = (funct7 == 7'h00 || funct7 == 7'h20);
                    default: regwrite_control = 1'b1;
                endcase
            end
            OP_LOAD: begin
                imm              = {{20{fetched_instruction[31]}}, fetched_instruction[31:20]};
                imm_control      = 1'b1;
                mem_read_control = load_ok;
                regwrite_control = load_ok;
            end
            OP_STORE: begin
                imm               = {{20{fetched_instruction[31]}}, fetched_instruction[31:25],
                                     fetched_instruction[11:7]};
                imm_control       = 1'b1;
                mem_write_control = store_ok;
            end
            default: ;
        endcase
    end

    assign operand_a = read_data1;
    assign operand_b = imm_control ? imm : read_data2;

    always_comb begin
        case (alu_control)
            ALU_AND:  alu_result = operand_a & operand_b;
            ALU_OR:   alu_result = operand_a | operand_b;
            ALU_ADD:  alu_result = operand_a + operand_b;
            ALU_SUB:  alu_result = operand_a - operand_b;
            ALU_SLT:  alu_result = {31'b0, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: alu_result = {31'b0, operand_a < operand_b};
            ALU_XOR:  alu_result = operand_a ^ operand_b;
            ALU_SLL:  alu_result = operand_a << operand_b[4:0];
            ALU_SRL:  alu_result = operand_a >> operand_b[4:0];
            ALU_SRA:  alu_result = $signed(operand_a) >>> operand_b[4:0];
            default:  alu_result = '0;
        endcase
    end

    assign zero_flag   = (alu_result == 32'd0);
    assign mem_address = alu_result;
    assign mem_data_in = read_data2;

    always_comb begin
        byte_enable = 4'b0000;
        store_data  = mem_data_in;
        if (mem_write_control) begin
            byte_enable = 4'b1111;
`ifdef RISCV_SUBWORD_EN
            // Replicate the narrow value across the word so the lane enable alone picks placement.
            case (funct3)
                3'b000: begin
                    byte_enable = 4'b0001 << mem_address[1:0];
                    store_data  = {4{mem_data_in[7:0]}};
                end
                3'b001: begin
                    byte_enable = mem_address[1] ? 4'b1100 : 4'b0011;
                    store_data  = {2{mem_data_in[15:0]}};
                end
                default: ;
            endcase
`endif
        end
    end

`ifdef RISCV_SUBWORD_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        case (mem_address[1:0])
            2'b00:   load_byte = mem_data_out[7:0];
            2'b01:   load_byte = mem_data_out[15:8];
            2'b10:   load_byte = mem_data_out[23:16];
            default: load_byte = mem_data_out[31:24];
        endcase
        load_half = mem_address[1] ? mem_data_out[31:16] : mem_data_out[15:0];
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'b0, load_byte};
            3'b101:  load_data = {16'b0, load_half};
            default: load_data = mem_data_out;
        endcase
    end
`else
    assign load_data = mem_data_out;
`endif

    assign reg_write_data = mem_read_control ? load_data : alu_result;
endmodule

// File: tb/tb_riscv_processor.sv
// Scoreboard bench for riscv_processor: expectations are queued per cycle and drained at negedges.
module tb_riscv_processor;
    localparam int IMEM_DEPTH = 256;
    localparam int DMEM_DEPTH = 256;
    localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_INSTR = 3, K_ZERO = 4;
`ifdef RISCV_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_out, instruction_out;

    typedef struct {
        int          cycle;
        int          kind;
        int          idx;
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] prog_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    riscv_processor #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_out          (pc_out),
        .instruction_out (instruction_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [11:0] imm,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic void push(input int cycle, input int kind, input int idx,
                                 input logic [31:0] value, input string name);
        exp_t e;
        e.cycle = cycle; e.kind = kind; e.idx = idx; e.value = value; e.name = name;
        sb_q.push_back(e);
    endfunction

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            K_REG:   return dut.register_file_unit.reg_array[idx];
            K_MEM:   return dut.memory_unit.memory[idx];
            K_PC:    return pc_out;
            K_INSTR: return instruction_out;
            default: return {31'b0, dut.zero_flag};
        endcase
    endfunction

    task automatic set_reg(input int idx, input logic [31:0] v);
        dut.register_file_unit.reg_array[idx] = v;
    endtask

    task automatic set_mem(input int idx, input logic [31:0] v);
        dut.memory_unit.memory[idx] = v;
    endtask

    // Asserts reset, loads prog_q (rest of imem is NOP) and leaves reset low at a negedge.
    task automatic load_program();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < IMEM_DEPTH; i++)
            dut.instruction_fetch_unit.instruction_memory[i] = (i < prog_q.size()) ? prog_q[i] : 32'h0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        prog_q = '{enc_i(7'h13, 12'd5, 5'd0, 3'b000, 5'd1), 32'h0, enc_i(7'h13, 12'd1, 5'd1, 3'b000, 5'd2)};
        load_program();
        dut.instruction_fetch_unit.instruction_memory[255] = enc_i(7'h13, 12'h055, 5'd0, 3'b000, 5'd3);
        set_reg(1, 32'h55); set_reg(3, 32'h0);
        @(negedge clk);
        push(0, K_PC, 0, 32'h0, "reset_pc");
        push(0, K_INSTR, 0, prog_q[0], "reset_instr");
        push(0, K_REG, 1, 32'h55, "reset_no_write");
        push(1, K_PC, 0, 32'h4, "pc_step1");
        push(1, K_REG, 1, 32'h5, "addi_x1");
        push(2, K_PC, 0, 32'h8, "pc_step2");
        push(2, K_INSTR, 0, prog_q[2], "instr_at_8");
        push(3, K_REG, 2, 32'h6, "addi_x2");
        push(255, K_PC, 0, 32'h3FC, "pc_last");
        push(256, K_PC, 0, 32'h0, "pc_wrap");
        push(256, K_REG, 3, 32'h55, "last_word_exec");
        push(256, K_INSTR, 0, prog_q[0], "instr_wrap");
        release_reset();
        for (int c = 0; c < 1000; c++) begin
            while (sb_q.size() > 0 && sb_q[0].cycle == c) begin
                e = sb_q.pop_front(); obs = observe(e.kind, e.idx); vectors++;
                if (obs !== e.value) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.value);
                end
            end
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL %s: cycle budget expired", sb_q[0].name); sb_q.delete();
        end
    endtask

    task automatic test_stores();
        exp_t e;
        logic [31:0] obs;
        prog_q = '{32'h00530223, 32'h00742023, enc_s(12'd3, 5'd5, 5'd6, 3'b001),
                   enc_s(12'd1, 5'd7, 5'd6, 3'b000), enc_s(12'd3, 5'd5, 5'd6, 3'b010)};
        load_program();
        set_reg(5, 32'hAAAAAAAA); set_reg(6, 32'h4); set_reg(7, 32'hBBBBBBBB); set_reg(8, 32'hC);
        set_reg(3, 32'h3333); set_reg(4, 32'h4444);
        set_mem(1, 32'h01020304); set_mem(2, 32'h12345678); set_mem(3, 32'h0);
        push(1, K_MEM, 2, SUBWORD ? 32'h123456AA : 32'h12345678, "sb_lane0");
        push(2, K_MEM, 3, 32'hBBBBBBBB, "sw_word");
        push(3, K_MEM, 1, SUBWORD ? 32'hAAAA0304 : 32'h01020304, "sh_upper_odd");
        push(4, K_MEM, 1, SUBWORD ? 32'hAAAABB04 : 32'h01020304, "sb_lane1");
        push(5, K_MEM, 1, 32'hAAAAAAAA, "sw_misaligned");
        push(5, K_REG, 3, 32'h3333, "store_no_regwr3");
        push(5, K_REG, 4, 32'h4444, "store_no_regwr4");
        release_reset();
        for (int c = 0; c < 1000; c++) begin
            while (sb_q.size() > 0 && sb_q[0].cycle == c) begin
                e = sb_q.pop_front(); obs = observe(e.kind, e.idx); vectors++;
                if (obs !== e.value) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.value);
                end
            end
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL %s: cycle budget expired", sb_q[0].name); sb_q.delete();
        end
    endtask

    task automatic test_loads();
        exp_t e;
        logic [31:0] obs;
        prog_q = '{enc_i(7'h03, 12'd0, 5'd5, 3'b010, 5'd6),  enc_i(7'h03, 12'd12, 5'd5, 3'b000, 5'd7),
                   enc_i(7'h03, 12'd5, 5'd5, 3'b000, 5'd9),  enc_i(7'h03, 12'd5, 5'd5, 3'b100, 5'd10),
                   enc_i(7'h03, 12'd6, 5'd5, 3'b001, 5'd11), enc_i(7'h03, 12'd7, 5'd5, 3'b101, 5'd12),
                   enc_i(7'h03, 12'd6, 5'd5, 3'b010, 5'd13), enc_i(7'h03, 12'd0, 5'd5, 3'b011, 5'd14)};
        load_program();
        set_reg(5, 32'h0); set_reg(6, 32'h6); set_reg(7, 32'h7); set_reg(9, 32'h9);
        set_reg(10, 32'hA); set_reg(11, 32'hB); set_reg(12, 32'hC); set_reg(13, 32'hD); set_reg(14, 32'hE);
        set_mem(0, 32'h11111111); set_mem(1, 32'h80F0A07F); set_mem(3, 32'h44444444);
        push(1, K_REG, 6, 32'h11111111, "lw");
        push(2, K_REG, 7, SUBWORD ? 32'h00000044 : 32'h7, "lb_pos");
        push(3, K_REG, 9, SUBWORD ? 32'hFFFFFFA0 : 32'h9, "lb_neg");
        push(4, K_REG, 10, SUBWORD ? 32'h000000A0 : 32'hA, "lbu");
        push(5, K_REG, 11, SUBWORD ? 32'hFFFF80F0 : 32'hB, "lh_upper");
        push(6, K_REG, 12, SUBWORD ? 32'h000080F0 : 32'hC, "lhu_odd");
        push(7, K_REG, 13, 32'h80F0A07F, "lw_misaligned");
        push(8, K_REG, 14, 32'hE, "load_bad_f3");
        release_reset();
        for (int c = 0; c < 1000; c++) begin
            while (sb_q.size() > 0 && sb_q[0].cycle == c) begin
                e = sb_q.pop_front(); obs = observe(e.kind, e.idx); vectors++;
                if (obs !== e.value) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.value);
                end
            end
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL %s: cycle budget expired", sb_q[0].name); sb_q.delete();
        end
    endtask

    task automatic test_alu_imm();
        exp_t e;
        logic [31:0] obs;
        prog_q = '{enc_i(7'h13, 12'd10, 5'd5, 3'b000, 5'd7),    enc_i(7'h13, 12'd4, 5'd6, 3'b110, 5'd12),
                   enc_i(7'h13, 12'hFFF, 5'd5, 3'b010, 5'd13),  enc_i(7'h13, 12'hFFF, 5'd5, 3'b011, 5'd14),
                   enc_i(7'h13, 12'hFFF, 5'd6, 3'b100, 5'd15),  enc_i(7'h13, 12'd3, 5'd6, 3'b111, 5'd16),
                   enc_i(7'h13, 12'h01F, 5'd5, 3'b001, 5'd17),  enc_i(7'h13, 12'h004, 5'd17, 3'b101, 5'd18),
                   enc_i(7'h13, 12'h404, 5'd17, 3'b101, 5'd19), enc_i(7'h13, 12'd7, 5'd5, 3'b000, 5'd0),
                   enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd20),     32'hFFFFFFFF, 32'h0};
        load_program();
        set_reg(5, 32'h1); set_reg(6, 32'h2); set_reg(13, 32'h13); set_reg(20, 32'h20); set_reg(31, 32'h31);
        push(1, K_REG, 7, 32'hB, "addi");
        push(2, K_REG, 12, 32'h6, "ori");
        push(3, K_REG, 13, 32'h0, "slti");
        push(4, K_REG, 14, 32'h1, "sltiu");
        push(5, K_REG, 15, 32'hFFFFFFFD, "xori");
        push(6, K_REG, 16, 32'h2, "andi");
        push(7, K_REG, 17, 32'h80000000, "slli");
        push(8, K_REG, 18, 32'h08000000, "srli");
        push(9, K_REG, 19, 32'hF8000000, "srai");
        push(11, K_REG, 20, 32'h0, "x0_reads_zero");
        push(12, K_REG, 31, 32'h31, "illegal_op_nop");
        push(13, K_PC, 0, 32'h34, "pc_after_nops");
        release_reset();
        for (int c = 0; c < 1000; c++) begin
            while (sb_q.size() > 0 && sb_q[0].cycle == c) begin
                e = sb_q.pop_front(); obs = observe(e.kind, e.idx); vectors++;
                if (obs !== e.value) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.value);
                end
            end
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL %s: cycle budget expired", sb_q[0].name); sb_q.delete();
        end
    endtask

    task automatic test_alu_reg();
        exp_t e;
        logic [31:0] obs;
        prog_q = '{enc_r(7'h00, 5'd5, 5'd6, 3'b000, 5'd7),  enc_r(7'h20, 5'd6, 5'd5, 3'b000, 5'd7),
                   enc_r(7'h20, 5'd5, 5'd5, 3'b000, 5'd9),  enc_r(7'h00, 5'd6, 5'd5, 3'b001, 5'd10),
                   enc_r(7'h00, 5'd5, 5'd7, 3'b010, 5'd11), enc_r(7'h00, 5'd5, 5'd7, 3'b011, 5'd12),
                   enc_r(7'h00, 5'd6, 5'd7, 3'b100, 5'd13), enc_r(7'h00, 5'd6, 5'd7, 3'b101, 5'd14),
                   enc_r(7'h20, 5'd6, 5'd7, 3'b101, 5'd15), enc_r(7'h00, 5'd6, 5'd5, 3'b110, 5'd16),
                   enc_r(7'h00, 5'd6, 5'd7, 3'b111, 5'd17), enc_r(7'h00, 5'd19, 5'd5, 3'b001, 5'd18)};
        load_program();
        set_reg(5, 32'h1); set_reg(6, 32'h2); set_reg(9, 32'h99); set_reg(12, 32'h12); set_reg(19, 32'h21);
        push(0, K_ZERO, 0, 32'h0, "zero_flag_add");
        push(1, K_REG, 7, 32'h3, "add");
        push(1, K_ZERO, 0, 32'h0, "zero_flag_sub_neg");
        push(2, K_REG, 7, 32'hFFFFFFFF, "sub");
        push(2, K_ZERO, 0, 32'h1, "zero_flag_sub_zero");
        push(3, K_REG, 9, 32'h0, "sub_zero");
        push(4, K_REG, 10, 32'h4, "sll");
        push(5, K_REG, 11, 32'h1, "slt");
        push(6, K_REG, 12, 32'h0, "sltu");
        push(7, K_REG, 13, 32'hFFFFFFFD, "xor");
        push(8, K_REG, 14, 32'h3FFFFFFF, "srl");
        push(9, K_REG, 15, 32'hFFFFFFFF, "sra");
        push(10, K_REG, 16, 32'h3, "or");
        push(11, K_REG, 17, 32'h2, "and");
        push(12, K_REG, 18, 32'h2, "sll_shamt_5bit");
        release_reset();
        for (int c = 0; c < 1000; c++) begin
            while (sb_q.size() > 0 && sb_q[0].cycle == c) begin
                e = sb_q.pop_front(); obs = observe(e.kind, e.idx); vectors++;
                if (obs !== e.value) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.value);
                end
            end
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL %s: cycle budget expired", sb_q[0].name); sb_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] obs;
        prog_q = {};
        for (int i = 0; i < 8; i++) prog_q.push_back(enc_i(7'h13, 12'd1, 5'd1, 3'b000, 5'd1));
        load_program();
        set_reg(1, 32'h0);
        push(3, K_REG, 1, 32'h3, "chain_x1");
        push(3, K_PC, 0, 32'hC, "chain_pc");
        release_reset();
        for (int c = 0; c < 1000; c++) begin
            while (sb_q.size() > 0 && sb_q[0].cycle == c) begin
                e = sb_q.pop_front(); obs = observe(e.kind, e.idx); vectors++;
                if (obs !== e.value) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.value);
                end
            end
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL %s: cycle budget expired", sb_q[0].name); sb_q.delete();
        end
        // Mid-program reset: pc returns to 0 while the register file keeps its contents.
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        push(0, K_PC, 0, 32'h0, "midreset_pc");
        push(0, K_REG, 1, 32'h3, "midreset_regs_kept");
        push(2, K_REG, 1, 32'h5, "resume_x1");
        push(2, K_PC, 0, 32'h8, "resume_pc");
        release_reset();
        for (int c = 0; c < 1000; c++) begin
            while (sb_q.size() > 0 && sb_q[0].cycle == c) begin
                e = sb_q.pop_front(); obs = observe(e.kind, e.idx); vectors++;
                if (obs !== e.value) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.value);
                end
            end
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL %s: cycle budget expired", sb_q[0].name); sb_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_alu_imm();
        test_alu_reg();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
